// File: rtl/md_issue_queue.sv
// md_issue_queue: in-order issue queue for paired multiply/divide micro-ops.
// Each entry holds one pair packet (inst1 reads HI/LO and writes the high
// half, inst2 reads src1/src2 and writes the low half) plus four source-ready
// bits that are set by writeback wakeup broadcasts. Only the head entry may
// issue; its tags drive the PRF read ports directly.
//
// Optional feature: define MD_IQ_PERF_EN to add two saturating 32-bit
// performance counters (perf_full_cyc, perf_head_wait_cyc). Both clear on
// reset only.
module md_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int PHY_W    = 6,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 8,
  parameter int WK_PORTS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,

  // dispatch side
  input  logic                        disp_valid,
  output logic                        disp_allowin,
  input  logic [OP_W-1:0]             disp_op,
  input  logic                        disp_rf_we1,
  input  logic                        disp_rf_we2,
  input  logic [PHY_W-1:0]            disp_dest1,
  input  logic [PHY_W-1:0]            disp_dest2,
  input  logic [ROB_W-1:0]            disp_rob1,
  input  logic [ROB_W-1:0]            disp_rob2,
  input  logic [PHY_W-1:0]            disp_hi,
  input  logic [PHY_W-1:0]            disp_lo,
  input  logic [PHY_W-1:0]            disp_src1,
  input  logic [PHY_W-1:0]            disp_src2,
  input  logic [3:0]                  disp_rdy,

  // writeback wakeup broadcasts
  input  logic [WK_PORTS-1:0]         wk_valid,
  input  logic [WK_PORTS*PHY_W-1:0]   wk_tag,

  // issue side
  output logic                        iss_valid,
  input  logic                        md_allowin,
  output logic [OP_W-1:0]             iss_op,
  output logic                        iss_rf_we1,
  output logic                        iss_rf_we2,
  output logic [PHY_W-1:0]            iss_dest1,
  output logic [PHY_W-1:0]            iss_dest2,
  output logic [ROB_W-1:0]            iss_rob1,
  output logic [ROB_W-1:0]            iss_rob2,
  output logic [PHY_W-1:0]            iss_hi,
  output logic [PHY_W-1:0]            iss_lo,
  output logic [PHY_W-1:0]            iss_src1,
  output logic [PHY_W-1:0]            iss_src2,

  output logic [$clog2(DEPTH):0]      count
`ifdef MD_IQ_PERF_EN
  ,
  output logic [31:0]                 perf_full_cyc,
  output logic [31:0]                 perf_head_wait_cyc
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Source slot k: 0=hi, 1=lo, 2=src1, 3=src2 (same order as disp_rdy).
  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic                  rf_we1;
    logic                  rf_we2;
    logic [PHY_W-1:0]      dest1;
    logic [PHY_W-1:0]      dest2;
    logic [ROB_W-1:0]      rob1;
    logic [ROB_W-1:0]      rob2;
    logic [3:0][PHY_W-1:0] src;
  } payload_t;

  // True when any strobed wakeup port carries the given tag.
  function automatic logic wk_hit(input logic [WK_PORTS-1:0]       v,
                                  input logic [WK_PORTS*PHY_W-1:0] t,
                                  input logic [PHY_W-1:0]          tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < WK_PORTS; i++) begin
      if (v[i] && (t[i*PHY_W +: PHY_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  payload_t                  payload_q [DEPTH];
  payload_t                  payload_d [DEPTH];
  logic [DEPTH-1:0]          vld_q, vld_d;
  logic [DEPTH-1:0][3:0]     rdy_q, rdy_d;
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;

  payload_t                  disp_payload;
  logic [3:0]                disp_rdy_cap;
  payload_t                  head_payload;
  logic                      disp_fire;
  logic                      iss_fire;

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  // No bypass on full: a slot freed by issue is only visible next cycle.
  assign disp_allowin = (count_q != FULL_CNT);
  assign iss_valid    = vld_q[head_q] && (&rdy_q[head_q]);
  assign disp_fire    = disp_valid && disp_allowin && !flush;
  assign iss_fire     = iss_valid && md_allowin && !flush;

  // Pack the incoming pair and capture its ready bits, including zero-tag
  // sources and same-cycle wakeups so no broadcast is missed at dispatch.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    disp_payload        = '0;
    disp_rdy_cap        = '0;
    disp_payload.op     = disp_op;
    disp_payload.rf_we1 = disp_rf_we1;
    disp_payload.rf_we2 = disp_rf_we2;
    disp_payload.dest1  = disp_dest1;
    disp_payload.dest2  = disp_dest2;
    disp_payload.rob1   = disp_rob1;
    disp_payload.rob2   = disp_rob2;
    disp_payload.src    = {disp_src2, disp_src1, disp_lo, disp_hi};
    for (int k = 0; k < 4; k++) begin
      disp_rdy_cap[k] = disp_rdy[k]
                     || (disp_payload.src[k] == '0)
                     || wk_hit(wk_valid, wk_tag, disp_payload.src[k]);
    end
  end

  // Next-state: wakeup, issue at head, dispatch at tail; flush overrides all.
  always_comb begin
    payload_d = payload_q;
    vld_d     = vld_q;
    rdy_d     = rdy_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < 4; k++) begin
        if (vld_q[e] && wk_hit(wk_valid, wk_tag, payload_q[e].src[k])) begin
          rdy_d[e][k] = 1'b1;
        end
      end
    end

    if (iss_fire) begin
      vld_d[head_q] = 1'b0;
      rdy_d[head_q] = '0;
      head_d        = head_q + PTR_W'(1);
    end

    // Head and tail only coincide when empty (no issue) or full (no dispatch),
    // so the two updates above and below never target the same live slot.
    if (disp_fire) begin
      payload_d[tail_q] = disp_payload;
      vld_d[tail_q]     = 1'b1;
      rdy_d[tail_q]     = disp_rdy_cap;
      tail_d            = tail_q + PTR_W'(1);
    end

    unique case ({disp_fire, iss_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      vld_d   = '0;
      rdy_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state: pointers, occupancy, valid and ready bits.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      vld_q   <= '0;
      rdy_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; its contents are only consumed
    // while the matching valid bit is set, and that bit is reset.
    for (int e = 0; e < DEPTH; e++) begin
      payload_q[e] <= payload_d[e];
    end
  end

  // ---------------------------------------------------------------------
  // Head presentation (PRF read addresses come straight from the head)
  // ---------------------------------------------------------------------
  assign head_payload = payload_q[head_q];
  assign iss_op       = head_payload.op;
  assign iss_rf_we1   = head_payload.rf_we1;
  assign iss_rf_we2   = head_payload.rf_we2;
  assign iss_dest1    = head_payload.dest1;
  assign iss_dest2    = head_payload.dest2;
  assign iss_rob1     = head_payload.rob1;
  assign iss_rob2     = head_payload.rob2;
  assign iss_hi       = head_payload.src[0];
  assign iss_lo       = head_payload.src[1];
  assign iss_src1     = head_payload.src[2];
  assign iss_src2     = head_payload.src[3];
  assign count        = count_q;

`ifdef MD_IQ_PERF_EN
  // ---------------------------------------------------------------------
  // Performance counters (saturating, cleared by reset only)
  // ---------------------------------------------------------------------
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  // Count dispatch back-pressure cycles and head-blocked cycles.
  always_comb begin
    perf_full_d = perf_full_q;
    perf_wait_d = perf_wait_q;
    if ((count_q == FULL_CNT) && disp_valid && (perf_full_q != '1)) begin
      perf_full_d = perf_full_q + 32'd1;
    end
    if (vld_q[head_q] && !(&rdy_q[head_q]) && (perf_wait_q != '1)) begin
      perf_wait_d = perf_wait_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_q <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_full_q <= perf_full_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_full_cyc      = perf_full_q;
  assign perf_head_wait_cyc = perf_wait_q;
`endif

endmodule

// File: tb/tb_md_issue_queue.sv
// tb_md_issue_queue: directed scenarios followed by a randomized phase.
// A queue-based reference model advances on each rising edge; accepted
// dispatches push their expected issue packet onto a scoreboard, and a
// monitor on the falling edge checks handshake outputs and pops/compares the
// scoreboard on every issue handshake.
module tb_md_issue_queue;

  localparam int DEPTH    = 4;
  localparam int PHY_W    = 6;
  localparam int ROB_W    = 4;
  localparam int OP_W     = 8;
  localparam int WK_PORTS = 4;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                      clk;
  logic                      reset;
  logic                      flush;
  logic                      disp_valid;
  logic                      disp_allowin;
  logic [OP_W-1:0]           disp_op;
  logic                      disp_rf_we1, disp_rf_we2;
  logic [PHY_W-1:0]          disp_dest1, disp_dest2;
  logic [ROB_W-1:0]          disp_rob1, disp_rob2;
  logic [PHY_W-1:0]          disp_hi, disp_lo, disp_src1, disp_src2;
  logic [3:0]                disp_rdy;
  logic [WK_PORTS-1:0]       wk_valid;
  logic [WK_PORTS*PHY_W-1:0] wk_tag;
  logic                      iss_valid;
  logic                      md_allowin;
  logic [OP_W-1:0]           iss_op;
  logic                      iss_rf_we1, iss_rf_we2;
  logic [PHY_W-1:0]          iss_dest1, iss_dest2;
  logic [ROB_W-1:0]          iss_rob1, iss_rob2;
  logic [PHY_W-1:0]          iss_hi, iss_lo, iss_src1, iss_src2;
  logic [CNT_W-1:0]          count;
`ifdef MD_IQ_PERF_EN
  logic [31:0]               perf_full_cyc, perf_head_wait_cyc;
`endif

  md_issue_queue #(
    .DEPTH(DEPTH), .PHY_W(PHY_W), .ROB_W(ROB_W), .OP_W(OP_W), .WK_PORTS(WK_PORTS)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_allowin(disp_allowin), .disp_op(disp_op),
    .disp_rf_we1(disp_rf_we1), .disp_rf_we2(disp_rf_we2),
    .disp_dest1(disp_dest1), .disp_dest2(disp_dest2),
    .disp_rob1(disp_rob1), .disp_rob2(disp_rob2),
    .disp_hi(disp_hi), .disp_lo(disp_lo), .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_rdy(disp_rdy), .wk_valid(wk_valid), .wk_tag(wk_tag),
    .iss_valid(iss_valid), .md_allowin(md_allowin), .iss_op(iss_op),
    .iss_rf_we1(iss_rf_we1), .iss_rf_we2(iss_rf_we2),
    .iss_dest1(iss_dest1), .iss_dest2(iss_dest2),
    .iss_rob1(iss_rob1), .iss_rob2(iss_rob2),
    .iss_hi(iss_hi), .iss_lo(iss_lo), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .count(count)
`ifdef MD_IQ_PERF_EN
    , .perf_full_cyc(perf_full_cyc), .perf_head_wait_cyc(perf_head_wait_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected issue packet; tag[k]: 0=hi 1=lo 2=src1 3=src2.
  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic                  we1;
    logic                  we2;
    logic [PHY_W-1:0]      dest1;
    logic [PHY_W-1:0]      dest2;
    logic [ROB_W-1:0]      rob1;
    logic [ROB_W-1:0]      rob2;
    logic [3:0][PHY_W-1:0] tag;
  } pkt_t;

  typedef struct packed {
    pkt_t       p;
    logic [3:0] rdy;
  } ment_t;

  ment_t mq[$];     // reference model: oldest entry first
  pkt_t  exp_q[$];  // scoreboard of packets expected at issue
  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;
  int    exp_full = 0;
  int    exp_wait = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic wk_hit_m(input logic [PHY_W-1:0] tag);
    for (int i = 0; i < WK_PORTS; i++) begin
      if (wk_valid[i] && (wk_tag[i*PHY_W +: PHY_W] == tag)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: FIFO of pairs, ready bits per source.
  always @(posedge clk) begin
    ment_t e;
    logic  fire_i;
    logic  fire_d;
    if (reset) begin
      exp_full = 0;
      exp_wait = 0;
    end else begin
      if (mq.size() == DEPTH && disp_valid) exp_full++;
      if (mq.size() > 0 && !(&mq[0].rdy)) exp_wait++;
    end
    if (reset || flush) begin
      mq.delete();
      exp_q.delete();
    end else begin
      fire_i = (mq.size() > 0) && (&mq[0].rdy) && md_allowin;
      fire_d = disp_valid && (mq.size() < DEPTH);
      for (int j = 0; j < mq.size(); j++) begin
        e = mq[j];
        for (int k = 0; k < 4; k++) if (wk_hit_m(e.p.tag[k])) e.rdy[k] = 1'b1;
        mq[j] = e;
      end
      if (fire_i) void'(mq.pop_front());
      if (fire_d) begin
        e.p.op    = disp_op;
        e.p.we1   = disp_rf_we1;
        e.p.we2   = disp_rf_we2;
        e.p.dest1 = disp_dest1;
        e.p.dest2 = disp_dest2;
        e.p.rob1  = disp_rob1;
        e.p.rob2  = disp_rob2;
        e.p.tag   = {disp_src2, disp_src1, disp_lo, disp_hi};
        for (int k = 0; k < 4; k++)
          e.rdy[k] = disp_rdy[k] || (e.p.tag[k] == '0) || wk_hit_m(e.p.tag[k]);
        mq.push_back(e);
        exp_q.push_back(e.p);
      end
    end
  end

  // Monitor: handshake outputs every cycle, packet compare on each issue.
  always @(negedge clk) begin
    pkt_t p;
    logic exp_valid;
    if (mon_en && !reset) begin
      exp_valid = (mq.size() > 0) && (&mq[0].rdy);
      check("iss_valid", 64'(iss_valid), 64'(exp_valid));
      check("count", 64'(count), 64'(mq.size()));
      check("disp_allowin", 64'(disp_allowin), 64'(mq.size() != DEPTH));
      if (iss_valid && md_allowin && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL issue_unexpected got=rob%0h exp=none at %0t", iss_rob1, $time);
        end else begin
          p = exp_q.pop_front();
          check("iss_rob1", 64'(iss_rob1), 64'(p.rob1));
          check("iss_pkt", 64'({iss_op, iss_rf_we1, iss_rf_we2, iss_dest1, iss_dest2,
                                iss_rob1, iss_rob2, iss_src2, iss_src1, iss_lo, iss_hi}),
                64'(p));
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wk_valid   = '0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic set_disp(input int rob, input logic [PHY_W-1:0] hi, input logic [PHY_W-1:0] lo,
                          input logic [PHY_W-1:0] s1, input logic [PHY_W-1:0] s2,
                          input logic [3:0] rdy);
    disp_valid  = 1'b1;
    disp_op     = OP_W'($urandom);
    disp_rf_we1 = 1'($urandom);
    disp_rf_we2 = 1'($urandom);
    disp_dest1  = PHY_W'($urandom);
    disp_dest2  = PHY_W'($urandom);
    disp_rob1   = ROB_W'(rob);
    disp_rob2   = ROB_W'(rob + 8);
    disp_hi     = hi;
    disp_lo     = lo;
    disp_src1   = s1;
    disp_src2   = s2;
    disp_rdy    = rdy;
  endtask

  task automatic set_wk(input int port, input logic [PHY_W-1:0] tag);
    wk_valid[port]              = 1'b1;
    wk_tag[port*PHY_W +: PHY_W] = tag;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    md_allowin = 1'b1;
    wk_tag = '0;
    disp_rdy = '0;
    disp_op = '0; disp_rf_we1 = 1'b0; disp_rf_we2 = 1'b0;
    disp_dest1 = '0; disp_dest2 = '0; disp_rob1 = '0; disp_rob2 = '0;
    disp_hi = '0; disp_lo = '0; disp_src1 = '0; disp_src2 = '0;
    idle();

    // Basic issue: all-ready pair issues one cycle after dispatch.
    do_reset();
    check("s1_reset_allowin", 64'(disp_allowin), 64'd1);
    check("s1_reset_count", 64'(count), 64'd0);
    set_disp(1, 6'd1, 6'd2, 6'd3, 6'd4, 4'b1111);
    tick();
    idle();
    check("s1_iss_valid", 64'(iss_valid), 64'd1);
    check("s1_rob", 64'(iss_rob1), 64'd1);
    tick();
    check("s1_count_drained", 64'(count), 64'd0);

    // Wakeup: src1=7 waits until the cycle after its broadcast on port 2.
    set_disp(2, 6'd1, 6'd2, 6'd7, 6'd4, 4'b1011);
    tick();
    idle();
    repeat (3) tick();
    check("s2_wait", 64'(iss_valid), 64'd0);
    set_wk(2, 6'd7);
    tick();
    idle();
    check("s2_woken", 64'(iss_valid), 64'd1);
    tick();

    // Full queue: no slot bypass on the issue cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_disp(i + 1, PHY_W'(20 + i), 6'd0, 6'd0, 6'd0, 4'b1110);
      tick();
    end
    set_disp(5, 6'd1, 6'd2, 6'd3, 6'd4, 4'b1111);
    tick();
    check("s3_count_full", 64'(count), 64'd4);
    check("s3_allowin_full", 64'(disp_allowin), 64'd0);
    set_wk(0, 6'd20);
    tick();
    wk_valid = '0;
    check("s3_issue_cycle_allowin", 64'(disp_allowin), 64'd0);
    tick();
    check("s3_allowin_after", 64'(disp_allowin), 64'd1);
    tick();
    idle();
    check("s3_fifth_taken", 64'(count), 64'd4);
    set_wk(0, 6'd21);
    set_wk(1, 6'd22);
    set_wk(2, 6'd23);
    tick();
    idle();
    repeat (6) tick();

    // In-order issue with wrap; entry 2 is ready before entry 1.
    do_reset();
    set_disp(1, 6'd30, 6'd1, 6'd2, 6'd3, 4'b1110); tick();
    set_disp(2, 6'd1, 6'd2, 6'd3, 6'd4, 4'b1111); tick();
    set_disp(3, 6'd1, 6'd2, 6'd3, 6'd4, 4'b1111); tick();
    check("s4_blocked", 64'(iss_valid), 64'd0);
    set_disp(4, 6'd5, 6'd6, 6'd0, 6'd0, 4'b1111);
    set_wk(1, 6'd30);
    tick();
    wk_valid = '0;
    set_disp(5, 6'd9, 6'd9, 6'd9, 6'd9, 4'b1111); tick();
    set_disp(6, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000); tick();
    idle();
    repeat (8) tick();

    // Same-cycle capture of a wakeup at dispatch.
    do_reset();
    set_disp(7, 6'd12, 6'd1, 6'd2, 6'd3, 4'b1110);
    set_wk(0, 6'd12);
    tick();
    idle();
    check("s5_capture", 64'(iss_valid), 64'd1);
    tick();

    // Flush with three entries, concurrent dispatch and wakeup.
    do_reset();
    md_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(i + 1, PHY_W'(40 + i), 6'd1, 6'd2, 6'd3, 4'b1110);
      tick();
    end
    set_disp(9, 6'd1, 6'd2, 6'd3, 6'd4, 4'b1111);
    set_wk(0, 6'd40);
    set_wk(3, 6'd41);
    flush = 1'b1;
    tick();
    idle();
    check("s6_count", 64'(count), 64'd0);
    check("s6_iss_valid", 64'(iss_valid), 64'd0);
    check("s6_allowin", 64'(disp_allowin), 64'd1);
    md_allowin = 1'b1;
    tick();
    check("s6_nothing_enqueued", 64'(count), 64'd0);

    // Randomized traffic with small tag space so wakeups hit often.
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        set_disp(c, PHY_W'($urandom_range(0, 15)), PHY_W'($urandom_range(0, 15)),
                 PHY_W'($urandom_range(0, 15)), PHY_W'($urandom_range(0, 15)),
                 4'($urandom));
      for (int w = 0; w < WK_PORTS; w++)
        if ($urandom_range(0, 2) == 0) set_wk(w, PHY_W'($urandom_range(0, 15)));
      md_allowin = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle();
    md_allowin = 1'b1;
    repeat (4) tick();

`ifdef MD_IQ_PERF_EN
    check("perf_full_cyc", 64'(perf_full_cyc), 64'(exp_full));
    check("perf_head_wait_cyc", 64'(perf_head_wait_cyc), 64'(exp_wait));
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_issue_queue.md
Name: md_issue_queue

Overview:
- In-order issue queue for paired multiply/divide micro-ops; sits directly upstream of the mul/div execute unit.
- Accepts one pair packet per cycle from dispatch: inst1 reads HI/LO and writes the high half; inst2 reads src1/src2 and writes the low half.
- Tracks readiness of the four physical source tags through writeback wakeup broadcasts.
- Presents the head entry to the execute unit with a valid/allowin handshake; the PRF read ports are driven from the head tags.

Parameters:
- DEPTH, 4, number of pair entries (power of two, >=2)
- PHY_W, 6, physical register tag width
- ROB_W, 4, ROB entry number width
- OP_W, 8, operation code width
- WK_PORTS, 4, number of wakeup broadcast ports

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; empties queue
- disp_valid  in  1  dispatch offers a pair packet
- disp_allowin  out  1  queue can accept a packet this cycle
- disp_op  in  OP_W  operation code
- disp_rf_we1 / disp_rf_we2  in  1 each  destination write enables
- disp_dest1 / disp_dest2  in  PHY_W each  physical destinations
- disp_rob1 / disp_rob2  in  ROB_W each  ROB entry numbers
- disp_hi, disp_lo, disp_src1, disp_src2  in  PHY_W each  source tags
- disp_rdy  in  4  initial ready bits {src2,src1,lo,hi}
- wk_valid  in  WK_PORTS  wakeup strobes
- wk_tag  in  WK_PORTS*PHY_W  wakeup tags, port i at [i*PHY_W +: PHY_W]
- iss_valid  out  1  head valid and all four sources ready
- md_allowin  in  1  execute unit accepts
- iss_op, iss_rf_we1, iss_rf_we2, iss_dest1, iss_dest2, iss_rob1, iss_rob2  out  as dispatch  head fields
- iss_hi, iss_lo, iss_src1, iss_src2  out  PHY_W each  PRF read addresses for head
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count register separate.
- Reset or flush: head=tail=count=0, all entry valid bits and ready bits cleared. iss_valid=0, disp_allowin=1. Field outputs reflect entry 0 contents, with no defined value.
- disp_allowin = (count != DEPTH). No bypass when full: a simultaneous issue does not free a slot for the same cycle.
- Dispatch fires when disp_valid && disp_allowin && !flush: write at tail, tail++, count++.
- Issue fires when iss_valid && md_allowin && !flush: head++, count--. Dispatch and issue in the same cycle leave count unchanged.
- Ready bit per source, stored at dispatch as:
  - disp_rdy[k], OR
  - tag==0 (zero register is always ready), OR
  - the tag matches any same-cycle wk_valid port.
- Wakeup: each cycle, every valid entry's unready source whose tag equals wk_tag[i] with wk_valid[i] set becomes ready next cycle.
- A wakeup on tag 0 has no effect beyond the already-ready state.
- iss_valid is combinational from the head entry: valid && all four ready bits. It does not see same-cycle wakeups (one-cycle wakeup-to-issue latency).
- Strict in-order: only the head may issue; non-head ready entries wait.
- Once iss_valid is high, head fields stay stable until the handshake or a flush.
- Minimum latency: dispatch with all sources ready in cycle N → iss_valid in cycle N+1.
- Flush has priority over dispatch, issue and wakeup in the same cycle.

Optional Feature:
- Macro MD_IQ_PERF_EN.
- Defined: adds outputs perf_full_cyc (32b) and perf_head_wait_cyc (32b).
  - perf_full_cyc increments each cycle count==DEPTH && disp_valid.
  - perf_head_wait_cyc increments each cycle the head is valid but not all ready.
  - Both counters clear on reset only, not on flush, and saturate at all-ones.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Scenario 1, basic issue:
  - Reset, then dispatch one pair with disp_rdy=4'b1111, md_allowin=1.
  - Required: iss_valid=1 exactly one cycle later; fields match the dispatch; count returns to 0 the following cycle.
- Scenario 2, wakeup:
  - Dispatch with src1=7 unready and the rest ready; hold 3 cycles; assert wk_valid[2] with wk_tag port2=7.
  - Required: iss_valid stays 0 until the cycle after the wakeup, then 1.
- Scenario 3, full queue:
  - Dispatch 4 unready pairs.
  - Required: count=4, disp_allowin=0; a 5th disp_valid is not accepted.
  - Wake the head: on the issue cycle disp_allowin stays 0; it rises the cycle after.
- Scenario 4, in-order and wrap:
  - Dispatch 6 pairs with interleaved issue, and the second entry ready before the first.
  - Required: issue order matches ROB numbers 1..6; pointers wrap past 3→0 correctly.
- Scenario 5, same-cycle capture:
  - Dispatch with hi tag=12 unready while wk_valid[0] carries tag 12 in the same cycle.
  - Required: the entry is ready; iss_valid=1 the next cycle.
- Scenario 6, flush:
  - Flush with 3 entries, concurrent with disp_valid and wakeups.
  - Required next cycle: count=0, iss_valid=0, disp_allowin=1, and nothing from the flush cycle is enqueued.
